// File: rtl/nfc_pkg.sv
// Shared constants and types for the NAND page-command scheduler.
package nfc_pkg;

    localparam logic OP_READ = 1'b0;
    localparam logic OP_PROG = 1'b1;

    localparam logic ID_A = 1'b0;
    localparam logic ID_B = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_DONE = 3'd2,
        ST_RETRY     = 3'd3,
        ST_RESP      = 3'd4
    } state_t;

    // The round-robin pointer always moves to the side that was not just served.
    function automatic logic other_id(input logic id);
        return ~id;
    endfunction

endpackage

// File: rtl/nfc_op_scheduler_if.sv
// Job request, engine and response signals between the scheduler and its environment.
interface nfc_op_scheduler_if #(
    parameter int PAGE_W = 9
) ();

    logic              req_a_valid;
    logic              req_a_op;
    logic [PAGE_W-1:0] req_a_page;
    logic              req_a_ready;
    logic              req_b_valid;
    logic              req_b_op;
    logic [PAGE_W-1:0] req_b_page;
    logic              req_b_ready;
    logic              eng_start;
    logic              eng_op;
    logic [PAGE_W-1:0] eng_page;
    logic              eng_done;
    logic              eng_fail;
    logic              F_RB;
    logic              rsp_valid;
    logic              rsp_id;
    logic              rsp_ok;
    logic              rsp_timeout;
    logic              busy;

    // Environment side: requesters, engine status and flash ready/busy.
    modport master (
        output req_a_valid, req_a_op, req_a_page,
        output req_b_valid, req_b_op, req_b_page,
        output eng_done, eng_fail, F_RB,
        input  req_a_ready, req_b_ready,
        input  eng_start, eng_op, eng_page,
        input  rsp_valid, rsp_id, rsp_ok, rsp_timeout, busy
    );

    // Scheduler side.
    modport slave (
        input  req_a_valid, req_a_op, req_a_page,
        input  req_b_valid, req_b_op, req_b_page,
        input  eng_done, eng_fail, F_RB,
        output req_a_ready, req_b_ready,
        output eng_start, eng_op, eng_page,
        output rsp_valid, rsp_id, rsp_ok, rsp_timeout, busy
    );

endinterface

// File: rtl/nfc_rr_arb2.sv
// Two-way round-robin pick: a lone requester always wins, a tie goes to rr_ptr.
module nfc_rr_arb2
    import nfc_pkg::*;
(
    input  logic valid_a,
    input  logic valid_b,
    input  logic rr_ptr,
    output logic gnt_any,
    output logic gnt_id
);

    // Choose the winner among the currently valid requesters.
    always_comb begin
        gnt_any = valid_a | valid_b;
        if (valid_a && valid_b) begin
            gnt_id = rr_ptr;
        end else if (valid_b) begin
            gnt_id = ID_B;
        end else begin
            gnt_id = ID_A;
        end
    end

endmodule

// File: rtl/nfc_op_scheduler.sv
// Shares one NAND page-command engine between requesters A and B, one job at a time,
// with ready/busy gating, a hung-engine timeout and bounded PROGRAM retries.
module nfc_op_scheduler
    import nfc_pkg::*;
#(
    parameter int PAGE_W    = 9,
    parameter int TIMEOUT   = 4096,
    parameter int MAX_RETRY = 2
) (
    input  logic                clk,
    input  logic                rst,
    nfc_op_scheduler_if.slave   bus
);

    localparam int TMO_W = $clog2(TIMEOUT) + 1;
    localparam int RTY_W = $clog2(MAX_RETRY + 1) + 1;

    state_t              state_r;
    state_t              state_n;

    logic                gnt_any_s;
    logic                gnt_id_s;
    logic                rr_ptr_r;

    logic                id_r;
    logic                op_r;
    logic [PAGE_W-1:0]   page_r;
    logic [TMO_W-1:0]    tmo_cnt_r;
    logic [RTY_W-1:0]    retry_cnt_r;
    logic                result_ok_r;
    logic                result_tmo_r;

    logic                latch_job_s;
    logic                tmo_clr_s;
    logic                tmo_inc_s;
    logic                retry_inc_s;
    logic                job_end_s;
    logic                set_result_s;
    logic                result_ok_s;
    logic                result_tmo_s;

    logic                req_a_ready_r;
    logic                req_b_ready_r;
    logic                eng_start_r;
    logic                rsp_valid_r;
    logic                rsp_id_r;
    logic                rsp_ok_r;
    logic                rsp_timeout_r;
    logic                busy_r;

    nfc_rr_arb2 u_arb (
        .valid_a (bus.req_a_valid),
        .valid_b (bus.req_b_valid),
        .rr_ptr  (rr_ptr_r),
        .gnt_any (gnt_any_s),
        .gnt_id  (gnt_id_s)
    );

    // Next-state and per-state control strobes.
    always_comb begin
        state_n      = state_r;
        latch_job_s  = 1'b0;
        tmo_clr_s    = 1'b0;
        tmo_inc_s    = 1'b0;
        retry_inc_s  = 1'b0;
        job_end_s    = 1'b0;
        set_result_s = 1'b0;
        result_ok_s  = 1'b0;
        result_tmo_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (gnt_any_s && bus.F_RB) begin
                    latch_job_s = 1'b1;
                    state_n     = ST_ISSUE;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                tmo_clr_s = 1'b1;
                state_n   = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (bus.eng_done) begin
                    if (bus.eng_fail && (op_r == OP_PROG) &&
                        (retry_cnt_r < RTY_W'(MAX_RETRY))) begin
                        retry_inc_s = 1'b1;
                        state_n     = ST_RETRY;
                    end else begin
                        set_result_s = 1'b1;
                        result_ok_s  = ~bus.eng_fail;
                        result_tmo_s = 1'b0;
                        state_n      = ST_RESP;
                    end
                end else if (tmo_cnt_r == TMO_W'(TIMEOUT - 1)) begin
                    set_result_s = 1'b1;
                    result_ok_s  = 1'b0;
                    result_tmo_s = 1'b1;
                    state_n      = ST_RESP;
                end else begin
                    tmo_inc_s = 1'b1;
                end
            end
            ST_RETRY: begin
                if (bus.F_RB) begin
                    state_n = ST_ISSUE;
                end else begin
                    state_n = ST_RETRY;
                end
            end
            ST_RESP: begin
                job_end_s = 1'b1;
                state_n   = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Job latch and round-robin pointer; op/page stay put until the next grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_r     <= ID_A;
            op_r     <= OP_READ;
            page_r   <= {PAGE_W{1'b0}};
            rr_ptr_r <= ID_A;
        end else begin
            if (latch_job_s) begin
                id_r   <= gnt_id_s;
                op_r   <= (gnt_id_s == ID_B) ? bus.req_b_op   : bus.req_a_op;
                page_r <= (gnt_id_s == ID_B) ? bus.req_b_page : bus.req_a_page;
            end
            if (job_end_s) begin
                rr_ptr_r <= other_id(id_r);
            end
        end
    end

    // Timeout and retry counters plus the captured job result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_r    <= {TMO_W{1'b0}};
            retry_cnt_r  <= {RTY_W{1'b0}};
            result_ok_r  <= 1'b0;
            result_tmo_r <= 1'b0;
        end else begin
            if (tmo_clr_s) begin
                tmo_cnt_r <= {TMO_W{1'b0}};
            end else if (tmo_inc_s) begin
                tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
            end
            if (job_end_s) begin
                retry_cnt_r <= {RTY_W{1'b0}};
            end else if (retry_inc_s) begin
                retry_cnt_r <= retry_cnt_r + RTY_W'(1);
            end
            if (set_result_s) begin
                result_ok_r  <= result_ok_s;
                result_tmo_r <= result_tmo_s;
            end
        end
    end

    // Registered outputs: pulses follow the ISSUE/RESP states, busy tracks the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_a_ready_r <= 1'b0;
            req_b_ready_r <= 1'b0;
            eng_start_r   <= 1'b0;
            rsp_valid_r   <= 1'b0;
            rsp_id_r      <= 1'b0;
            rsp_ok_r      <= 1'b0;
            rsp_timeout_r <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            req_a_ready_r <= (state_r == ST_ISSUE) && (retry_cnt_r == {RTY_W{1'b0}}) && (id_r == ID_A);
            req_b_ready_r <= (state_r == ST_ISSUE) && (retry_cnt_r == {RTY_W{1'b0}}) && (id_r == ID_B);
            eng_start_r   <= (state_r == ST_ISSUE);
            rsp_valid_r   <= (state_r == ST_RESP);
            rsp_id_r      <= (state_r == ST_RESP) ? id_r         : 1'b0;
            rsp_ok_r      <= (state_r == ST_RESP) ? result_ok_r  : 1'b0;
            rsp_timeout_r <= (state_r == ST_RESP) ? result_tmo_r : 1'b0;
            busy_r        <= (state_n != ST_IDLE);
        end
    end

    assign bus.req_a_ready = req_a_ready_r;
    assign bus.req_b_ready = req_b_ready_r;
    assign bus.eng_start   = eng_start_r;
    assign bus.eng_op      = op_r;
    assign bus.eng_page    = page_r;
    assign bus.rsp_valid   = rsp_valid_r;
    assign bus.rsp_id      = rsp_id_r;
    assign bus.rsp_ok      = rsp_ok_r;
    assign bus.rsp_timeout = rsp_timeout_r;
    assign bus.busy        = busy_r;

endmodule

// File: tb/tb_nfc_op_scheduler.sv
// Randomized bench for nfc_op_scheduler. A job-level model predicts the grant order
// (round robin), the cycle of every ready/start/response event and each response's
// fields from the scheduling rules; all other cycles must be quiet.
module tb_nfc_op_scheduler;
    import nfc_pkg::*;

    localparam int TMO  = 16;
    localparam int MAXR = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    nfc_op_scheduler_if #(.PAGE_W(9)) bus ();

    nfc_op_scheduler #(.PAGE_W(9), .TIMEOUT(TMO), .MAX_RETRY(MAXR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   done_at  = -100;
    int   stray_at = -100;
    logic done_fail = 1'b0;
    int   rbl_from = -100;
    int   rbl_to   = -100;
    logic rr_m = ID_A;

    logic [8:0] pg [2];
    logic       opv [2];
    bit         plan_fail [2][3];
    int         plan_dly  [2][3];
    int         plan_rbl  [2][3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Engine and flash inputs are pure functions of the cycle count and the plan.
    task automatic drive();
        bus.eng_done = (cyc == done_at) || (cyc == stray_at);
        bus.eng_fail = (cyc == done_at) ? done_fail : 1'($urandom);
        bus.F_RB     = !((cyc >= rbl_from) && (cyc < rbl_to));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        drive();
    endtask

    function automatic logic any_evt();
        return bus.req_a_ready | bus.req_b_ready | bus.eng_start | bus.rsp_valid;
    endfunction

    function automatic logic [31:0] outs();
        return {14'd0, bus.req_a_ready, bus.req_b_ready, bus.eng_start, bus.eng_op,
                bus.eng_page, bus.rsp_valid, bus.rsp_id, bus.rsp_ok, bus.rsp_timeout, bus.busy};
    endfunction

    task automatic quiet_until(input string tag, input int target);
        logic spur;
        spur = 1'b0;
        while (cyc < target) begin
            tick();
            if ((cyc < target) && any_evt()) spur = 1'b1;
        end
        chk({tag, "_quiet"}, 32'(spur), 32'd0);
    endtask

    task automatic set_req(input logic id, input logic v);
        if (id == ID_A) begin
            bus.req_a_valid = v; bus.req_a_op = opv[0]; bus.req_a_page = pg[0];
        end else begin
            bus.req_b_valid = v; bus.req_b_op = opv[1]; bus.req_b_page = pg[1];
        end
    endtask

    task automatic plan(input logic id, input logic op, input logic [8:0] page,
                        input bit f0, input int d0, input bit f1, input int d1,
                        input bit f2, input int d2, input int l0, input int l1);
        opv[id] = op; pg[id] = page;
        plan_fail[id][0] = f0; plan_dly[id][0] = d0; plan_rbl[id][0] = l0;
        plan_fail[id][1] = f1; plan_dly[id][1] = d1; plan_rbl[id][1] = l1;
        plan_fail[id][2] = f2; plan_dly[id][2] = d2; plan_rbl[id][2] = 0;
    endtask

    task automatic rand_plan(input logic id);
        opv[id] = 1'($urandom);
        pg[id]  = 9'($urandom);
        for (int k = 0; k < 3; k++) begin
            plan_fail[id][k] = 1'($urandom);
            plan_dly[id][k]  = ($urandom_range(0, 9) == 0) ? TMO + 2 : int'($urandom_range(0, TMO - 1));
            plan_rbl[id][k]  = int'($urandom_range(0, 4));
        end
    endtask

    // Serve one job whose ready pulse is expected at cycle g; returns the rsp cycle.
    task automatic serve(input logic id, input int g, output int r);
        int s, d, L, nxt;
        logic f, ok, to;
        ok = 1'b0; to = 1'b0; r = g;
        quiet_until("grant", g);
        chk("ready_a", 32'(bus.req_a_ready), 32'(id == ID_A));
        chk("ready_b", 32'(bus.req_b_ready), 32'(id == ID_B));
        set_req(id, 1'b0);
        s = g;
        for (int k = 0; k <= MAXR; k++) begin
            chk("start", 32'(bus.eng_start), 32'd1);
            chk("eng_op", 32'(bus.eng_op), 32'(opv[id]));
            chk("eng_page", 32'(bus.eng_page), 32'(pg[id]));
            chk("busy_job", 32'(bus.busy), 32'd1);
            d = plan_dly[id][k];
            f = plan_fail[id][k];
            if (d >= TMO) begin
                r = s + TMO + 1; ok = 1'b0; to = 1'b1;
                break;
            end
            done_at = s + d; done_fail = f; drive();
            if (f && (opv[id] == OP_PROG) && (k < MAXR)) begin
                L = plan_rbl[id][k];
                rbl_from = s + d; rbl_to = s + d + L; drive();
                nxt = s + d + ((L > 1) ? L : 1) + 2;
                quiet_until("retry", nxt);
                chk("retry_noready", 32'(bus.req_a_ready | bus.req_b_ready), 32'd0);
                s = nxt;
            end else begin
                r = s + d + 2; ok = ~f; to = 1'b0;
                break;
            end
        end
        quiet_until("rsp", r);
        chk("rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("rsp_id", 32'(bus.rsp_id), 32'(id));
        chk("rsp_ok", 32'(bus.rsp_ok), 32'(ok));
        chk("rsp_timeout", 32'(bus.rsp_timeout), 32'(to));
        chk("busy_rsp", 32'(bus.busy), 32'd0);
        chk("page_hold", 32'(bus.eng_page), 32'(pg[id]));
        rr_m = ~id;
        if ($urandom_range(0, 2) == 0) stray_at = r + 1;
    endtask

    // One round: selected requesters raise valid together; F_RB held low for l0 cycles.
    task automatic round(input bit va, input bit vb, input int l0);
        int t, r;
        logic first;
        t = cyc;
        rbl_from = t; rbl_to = t + l0;
        if (va) set_req(ID_A, 1'b1);
        if (vb) set_req(ID_B, 1'b1);
        drive();
        first = (va && vb) ? rr_m : (va ? ID_A : ID_B);
        serve(first, t + l0 + 2, r);
        if (va && vb) serve(~first, r + 2, r);
    endtask

    initial begin
        bus.req_a_valid = 1'b0; bus.req_a_op = 1'b0; bus.req_a_page = 9'd0;
        bus.req_b_valid = 1'b0; bus.req_b_op = 1'b0; bus.req_b_page = 9'd0;
        bus.eng_done = 1'b0; bus.eng_fail = 1'b0; bus.F_RB = 1'b1;
        rst = 1'b1;
        repeat (3) tick();
        chk("reset_outs", outs(), 32'd0);
        rst = 1'b0;
        rr_m = ID_A;

        // Both valid at reset exit: A then B, and again A then B.
        plan(ID_A, OP_READ, 9'h011, 0, 4, 0, 0, 0, 0, 0, 0);
        plan(ID_B, OP_PROG, 9'h022, 0, 6, 0, 0, 0, 0, 0, 0);
        round(1, 1, 0);
        plan(ID_A, OP_PROG, 9'h033, 0, 2, 0, 0, 0, 0, 0, 0);
        plan(ID_B, OP_READ, 9'h044, 0, 3, 0, 0, 0, 0, 0, 0);
        round(1, 1, 0);

        // A alone, READ page 5, clean completion.
        plan(ID_A, OP_READ, 9'h005, 0, 12, 0, 0, 0, 0, 0, 0);
        round(1, 0, 0);

        // B PROGRAM page 1FF failing every attempt, then A READ failing once.
        plan(ID_B, OP_PROG, 9'h1FF, 1, 3, 1, 5, 1, 7, 0, 2);
        round(0, 1, 0);
        plan(ID_A, OP_READ, 9'h0AA, 1, 5, 0, 0, 0, 0, 0, 0);
        round(1, 0, 0);

        // Hung engine times out; done on the terminal cycle still wins.
        plan(ID_A, OP_READ, 9'h100, 0, TMO + 5, 0, 0, 0, 0, 0, 0);
        round(1, 0, 0);
        plan(ID_B, OP_PROG, 9'h101, 0, TMO - 1, 0, 0, 0, 0, 0, 0);
        round(0, 1, 0);

        // Flash busy holds off the grant.
        plan(ID_A, OP_READ, 9'h0F0, 0, 1, 0, 0, 0, 0, 0, 0);
        round(1, 0, 10);

        // Reset during WAIT_DONE: everything drops, no response, then normal service.
        plan(ID_A, OP_PROG, 9'h077, 0, TMO + 5, 0, 0, 0, 0, 0, 0);
        set_req(ID_A, 1'b1);
        quiet_until("prerst", cyc + 2);
        chk("prerst_ready", 32'(bus.req_a_ready), 32'd1);
        set_req(ID_A, 1'b0);
        repeat (5) tick();
        rst = 1'b1;
        done_at = cyc + 1; done_fail = 1'b0;
        #1;
        chk("midrst_outs", outs(), 32'd0);
        repeat (2) tick();
        chk("midrst_outs2", outs(), 32'd0);
        rst = 1'b0;
        rr_m = ID_A;
        quiet_until("postrst", cyc + TMO + 4);
        plan(ID_A, OP_READ, 9'h055, 0, 7, 0, 0, 0, 0, 0, 0);
        round(1, 0, 0);

        // Randomized rounds.
        for (int i = 0; i < 40; i++) begin
            bit va, vb;
            va = 1'($urandom);
            vb = va ? 1'($urandom) : 1'b1;
            rand_plan(ID_A);
            rand_plan(ID_B);
            round(va, vb, int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
